// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the unified memory port of the
// arbiter so they travel as one connection between core, arbiter and memory.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // Instruction-fetch port
   logic              i_if_req;
   logic [ADDR_W-1:0] i_if_addr;
   logic              o_if_gnt;
   logic              o_if_rvalid;
   logic [DATA_W-1:0] o_if_rdata;

   // Load/store port
   logic              i_d_req;
   logic              i_d_we;
   logic [ADDR_W-1:0] i_d_addr;
   logic [DATA_W-1:0] i_d_wdata;
   logic [BE_W-1:0]   i_d_be;
   logic              o_d_gnt;
   logic              o_d_rvalid;
   logic [DATA_W-1:0] o_d_rdata;

   // Unified single-port memory
   logic              o_mem_en;
   logic              o_mem_we;
   logic [BE_W-1:0]   o_mem_be;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic [DATA_W-1:0] i_mem_rdata;

   // Core and memory side
   modport master (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
      input  o_d_gnt, o_d_rvalid, o_d_rdata,
      input  o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      output i_mem_rdata
   );

   // Arbiter side
   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
      output o_d_gnt, o_d_rvalid, o_d_rdata,
      output o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      input  i_mem_rdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store,
// with per-cycle arbitration, a fetch starvation guard and response routing by owner.
module unified_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_STARVE = 4
) (
   input logic                 i_clk,
   input logic                 i_resetn,
   unified_mem_arbiter_if.slave bus
);
   localparam int                BE_W         = DATA_W / 8;
   localparam int                CNT_W        = $clog2(MAX_STARVE + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIMIT = CNT_W'(MAX_STARVE);
   localparam logic [BE_W-1:0]   BE_ALL       = {BE_W{1'b1}};

   typedef enum logic [1:0] {
      OWNER_NONE,
      OWNER_IF,
      OWNER_D
   } owner_t;

   owner_t           owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             if_win;
   logic             d_win;

   // Data normally wins; a fetch that has lost MAX_STARVE cycles in a row takes the slot.
   // Grants are gated by reset so nothing reaches the memory while reset is held.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      if_win = 1'b0;
      d_win  = 1'b0;
      if (i_resetn) begin
         if (bus.i_if_req && (!bus.i_d_req || starve_cnt == STARVE_LIMIT)) begin
            if_win = 1'b1;
         end else if (bus.i_d_req) begin
            d_win = 1'b1;
         end
      end
   end

   always_comb begin
      bus.o_mem_en    = if_win | d_win;
      bus.o_mem_we    = 1'b0;
      bus.o_mem_be    = '0;
      bus.o_mem_addr  = '0;
      bus.o_mem_wdata = '0;
      if (if_win) begin
         bus.o_mem_be   = BE_ALL;
         bus.o_mem_addr = bus.i_if_addr;
      end else if (d_win) begin
         bus.o_mem_we    = bus.i_d_we;
         bus.o_mem_be    = bus.i_d_we ? bus.i_d_be : BE_ALL;
         bus.o_mem_addr  = bus.i_d_addr;
         bus.o_mem_wdata = bus.i_d_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         owner      <= OWNER_NONE;
         starve_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         if (if_win) begin
            owner <= OWNER_IF;
         end else if (d_win && !bus.i_d_we) begin
            owner <= OWNER_D;
         end else begin
            owner <= OWNER_NONE;
         end

         if (if_win) begin
            starve_cnt <= '0;
         end else if (bus.i_if_req && starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   assign bus.o_if_gnt    = if_win;
   assign bus.o_d_gnt     = d_win;
   assign bus.o_if_rvalid = (owner == OWNER_IF);
   assign bus.o_d_rvalid  = (owner == OWNER_D);
   assign bus.o_if_rdata  = (owner == OWNER_IF) ? bus.i_mem_rdata : '0;
   assign bus.o_d_rdata   = (owner == OWNER_D)  ? bus.i_mem_rdata : '0;

   a_one_grant : assert property (@(posedge i_clk) disable iff (!i_resetn)
      !(bus.o_if_gnt && bus.o_d_gnt));

   a_starve_bound : assert property (@(posedge i_clk) disable iff (!i_resetn)
      starve_cnt <= STARVE_LIMIT);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: stimulus pushes expected read responses,
// a negedge monitor pops and compares them, including the one-cycle latency.
module tb_unified_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        q_if[$];
   exp_t        q_d[$];
   logic [31:0] mem[0:255];

   unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4)) dut (
      .i_clk    (clk),
      .i_resetn (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Behavioural single-port memory, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.o_mem_en) begin
         if (bus.o_mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.o_mem_be[b]) mem[bus.o_mem_addr[9:2]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
            end
         end else begin
            bus.i_mem_rdata <= mem[bus.o_mem_addr[9:2]];
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Response monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (bus.o_if_rvalid) begin
         if (q_if.size() == 0) begin
            check("if_unexpected_rvalid", 1, 0);
         end else begin
            e = q_if.pop_front();
            check("if_rdata", bus.o_if_rdata, e.data);
            check("if_latency", cyc, e.cyc + 1);
         end
      end else begin
         check("if_rdata_idle_zero", bus.o_if_rdata, 0);
      end
      if (bus.o_d_rvalid) begin
         if (q_d.size() == 0) begin
            check("d_unexpected_rvalid", 1, 0);
         end else begin
            e = q_d.pop_front();
            check("d_rdata", bus.o_d_rdata, e.data);
            check("d_latency", cyc, e.cyc + 1);
         end
      end else begin
         check("d_rdata_idle_zero", bus.o_d_rdata, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Drive one cycle of requests, check grants and the memory mux mid-cycle,
   // push expected read responses, then advance to just after the next edge.
   task automatic step(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] dbe,
                       input logic eig, input logic edg,
                       input logic [31:0] eid, input logic [31:0] edd,
                       input int es, input string tag);
      logic [31:0] ea;
      logic        ewe;
      logic [3:0]  ebe;
      bus.i_if_req  = ir;
      bus.i_if_addr = ia;
      bus.i_d_req   = dr;
      bus.i_d_we    = dwe;
      bus.i_d_addr  = da;
      bus.i_d_wdata = dwd;
      bus.i_d_be    = dbe;
      @(negedge clk);
      check({tag, "_if_gnt"}, bus.o_if_gnt, eig);
      check({tag, "_d_gnt"}, bus.o_d_gnt, edg);
      check({tag, "_mem_en"}, bus.o_mem_en, eig | edg);
      if (es >= 0) check({tag, "_starve"}, 64'(dut.starve_cnt), 64'(es));
      ea  = eig ? ia : (edg ? da : 32'h0);
      ewe = edg & dwe;
      ebe = eig ? 4'hF : (edg ? (dwe ? dbe : 4'hF) : 4'h0);
      check({tag, "_mem_addr"}, bus.o_mem_addr, ea);
      check({tag, "_mem_we"}, bus.o_mem_we, ewe);
      check({tag, "_mem_be"}, bus.o_mem_be, ebe);
      if (ewe) check({tag, "_mem_wdata"}, bus.o_mem_wdata, dwd);
      if (eig) q_if.push_back('{data: eid, cyc: cyc});
      if (edg && !dwe) q_d.push_back('{data: edd, cyc: cyc});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string tag);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, tag);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[16] = 32'h0;
      bus.i_mem_rdata = '0;

      // 1: reset held with both requests pending
      bus.i_if_req  = 1;
      bus.i_if_addr = 32'h0;
      bus.i_d_req   = 1;
      bus.i_d_we    = 0;
      bus.i_d_addr  = 32'h80;
      bus.i_d_wdata = 0;
      bus.i_d_be    = 0;
      repeat (2) begin
         @(negedge clk);
         check("rst_if_gnt", bus.o_if_gnt, 0);
         check("rst_d_gnt", bus.o_d_gnt, 0);
         check("rst_mem_en", bus.o_mem_en, 0);
         check("rst_mem_we", bus.o_mem_we, 0);
         check("rst_if_rvalid", bus.o_if_rvalid, 0);
         check("rst_d_rvalid", bus.o_d_rvalid, 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      step(1, 32'h0, 1, 0, 32'h80, 0, 0, 0, 1, 0, 32'hC0DE_0020, 0, "rel_first");

      // 2: fetch stream 0x0, 0x4, 0x8
      step(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'hC0DE_0000, 0, 1, "fetch0");
      step(1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 32'hC0DE_0001, 0, 0, "fetch4");
      step(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 32'hC0DE_0002, 0, 0, "fetch8");
      idle("idle_a");

      // 3: partial store then load of the same word
      step(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 0, 1, 0, 0, -1, "store40");
      step(0, 0, 1, 0, 32'h40, 0, 0, 0, 1, 0, 32'h0000_BEEF, -1, "load40");
      idle("idle_b");

      // 4: both requests held, starvation guard forces every fifth grant to fetch
      for (int k = 0; k < 10; k++) begin
         if (k % 5 == 4)
            step(1, 32'hC, 1, 0, 32'h84, 0, 0, 1, 0, 32'hC0DE_0003, 0, k % 5, "starve");
         else
            step(1, 32'hC, 1, 0, 32'h84, 0, 0, 0, 1, 0, 32'hC0DE_0021, k % 5, "starve");
      end

      // 5: simultaneous fetch 0x10 and load 0x80
      step(1, 32'h10, 1, 0, 32'h80, 0, 0, 0, 1, 0, 32'hC0DE_0020, 0, "both_load");
      step(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hC0DE_0004, 0, 1, "both_fetch");
      idle("idle_c");
      idle("idle_d");

      // 6: reset in the cycle after a load grant drops the response
      step(1, 32'h14, 1, 0, 32'h84, 0, 0, 0, 1, 0, 32'hC0DE_0021, 0, "pre_rst_load");
      void'(q_d.pop_back());
      rst_n = 0;
      bus.i_if_req = 0;
      bus.i_d_req  = 0;
      @(negedge clk);
      check("rst6_d_rvalid", bus.o_d_rvalid, 0);
      check("rst6_owner", 64'(dut.owner), 0);
      check("rst6_starve", 64'(dut.starve_cnt), 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      @(negedge clk);
      check("post_rst_d_rvalid", bus.o_d_rvalid, 0);
      check("post_rst_owner", 64'(dut.owner), 0);
      check("post_rst_starve", 64'(dut.starve_cnt), 0);
      @(posedge clk);
      #1;
      idle("idle_e");

      check("if_queue_empty", 64'(q_if.size()), 0);
      check("d_queue_empty", 64'(q_d.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
